// File: rtl/ahb_burst_master.sv
// ---------------------------------------------------------------------------
// ahb_burst_master
//   AHB-Lite bus master that turns single-burst commands from a local
//   controller into pipelined NONSEQ/SEQ word transfers (SINGLE, INCR4,
//   INCR8, INCR16). Read beats come back on rd_valid/rd_data. Each command
//   ends with one done pulse, and done_err marks an ERROR response or a
//   rejected command.
//
// Ports
//   HCLK, HRESET          bus clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_write/addr/len    burst direction, start byte address, length code
//   wr_pop, wr_data       write word request; wr_data is valid the cycle
//                         after wr_pop
//   rd_valid, rd_data     one pulse per completed read beat
//   done, done_err        per-command completion / error status
//   HSEL..HMASTERLOCK     AHB-Lite master outputs
//   HRDATA, HREADY, HRESP AHB-Lite slave response inputs
// ---------------------------------------------------------------------------
module ahb_burst_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  // command interface
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [1:0]            cmd_len,
  // write data source
  output logic                  wr_pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  // read data sink and status
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  done_err,
  // AHB-Lite master port
  output logic                  HSEL,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HMASTERLOCK,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  typedef enum logic [2:0] {
    S_IDLE,   // waiting for a command
    S_REJ,    // rejected command: one cycle with done/done_err
    S_ADDR0,  // first address phase (NONSEQ)
    S_SEQ,    // subsequent address phases (SEQ)
    S_LAST,   // IDLE address phase while the final data phase completes
    S_ERR     // second cycle of an ERROR response
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  state_t                  state_q, state_d;
  logic [1:0]              htrans_q, htrans_d;
  logic [ADDR_WIDTH-1:0]   haddr_q, haddr_d;
  logic                    hwrite_q, hwrite_d;
  logic [2:0]              hburst_q, hburst_d;
  logic [4:0]              beat_q, beat_d;       // address phases accepted
  logic [4:0]              nbeats_q, nbeats_d;   // beats in this burst
  logic                    dp_valid_q, dp_valid_d;
  logic                    dp_write_q, dp_write_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    done_q, done_d;
  logic                    done_err_q, done_err_d;
  logic                    wr_first_q;           // first cycle of a write data phase
  logic [DATA_WIDTH-1:0]   hwdata_q;

  // ---------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------
  logic [4:0]  cmd_beats;
  logic [2:0]  cmd_hburst;
  logic [10:0] cmd_end;
  logic        cmd_illegal;

  always_comb begin
    unique case (cmd_len)
      2'd0:    begin cmd_beats = 5'd1;  cmd_hburst = 3'b000; end
      2'd1:    begin cmd_beats = 5'd4;  cmd_hburst = 3'b011; end
      2'd2:    begin cmd_beats = 5'd8;  cmd_hburst = 3'b101; end
      default: begin cmd_beats = 5'd16; cmd_hburst = 3'b111; end
    endcase
  end

  // Offset just past the last byte within the current 1 KB page; anything
  // above 1024 means the burst would straddle a page.
  assign cmd_end     = {1'b0, cmd_addr[9:0]} + {4'b0000, cmd_beats, 2'b00};
  assign cmd_illegal = (cmd_addr[1:0] != 2'b00) || (cmd_end > 11'd1024);

  // ---------------------------------------------------------------------
  // Bus-phase qualifiers
  // ---------------------------------------------------------------------
  logic       err_first;
  logic [4:0] beat_inc;

  // First ERROR cycle: the slave holds HREADY low while flagging HRESP.
  assign err_first = dp_valid_q && HRESP && !HREADY;
  assign beat_inc  = beat_q + 5'd1;

  // ---------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    htrans_d   = htrans_q;
    haddr_d    = haddr_q;
    hwrite_d   = hwrite_q;
    hburst_d   = hburst_q;
    beat_d     = beat_q;
    nbeats_d   = nbeats_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;

    // A data phase starts on every edge that accepts a non-IDLE address
    // phase and ends on any edge with HREADY high.
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    if (HREADY) begin
      dp_valid_d = htrans_q[1];
      dp_write_d = hwrite_q;
    end

    rd_valid_d = dp_valid_q && !dp_write_q && HREADY && !HRESP;
    rd_data_d  = rd_valid_d ? HRDATA : rd_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_illegal) begin
            state_d    = S_REJ;
            done_d     = 1'b1;
            done_err_d = 1'b1;
          end else begin
            state_d  = S_ADDR0;
            htrans_d = TR_NONSEQ;
            haddr_d  = cmd_addr;
            hwrite_d = cmd_write;
            hburst_d = cmd_hburst;
            nbeats_d = cmd_beats;
            beat_d   = 5'd0;
          end
        end
      end

      S_REJ: state_d = S_IDLE;

      S_ADDR0, S_SEQ: begin
        if (err_first) begin
          // Drop the pending address phase; remaining beats are cancelled.
          state_d  = S_ERR;
          htrans_d = TR_IDLE;
        end else if (HREADY) begin
          beat_d = beat_inc;
          if (beat_inc == nbeats_q) begin
            state_d  = S_LAST;
            htrans_d = TR_IDLE;
          end else begin
            state_d  = S_SEQ;
            htrans_d = TR_SEQ;
            haddr_d  = haddr_q + ADDR_WIDTH'(4);
          end
        end
      end

      S_LAST: begin
        if (err_first) begin
          state_d = S_ERR;
        end else if (HREADY) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      S_ERR: begin
        if (HREADY) begin
          state_d    = S_IDLE;
          done_d     = 1'b1;
          done_err_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      htrans_q   <= TR_IDLE;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hburst_q   <= 3'b000;
      beat_q     <= 5'd0;
      nbeats_q   <= 5'd0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      wr_first_q <= 1'b0;
      hwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      htrans_q   <= htrans_d;
      haddr_q    <= haddr_d;
      hwrite_q   <= hwrite_d;
      hburst_q   <= hburst_d;
      beat_q     <= beat_d;
      nbeats_q   <= nbeats_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
      wr_first_q <= wr_pop;
      // Capture the popped word at the end of its first data-phase cycle
      // and hold it through any wait states.
      if (wr_first_q) hwdata_q <= wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // A pop coincides with the edge that accepts a write address phase; the
  // source returns the word one cycle later, i.e. in the first data-phase
  // cycle, where it is forwarded directly and then held from hwdata_q.
  assign wr_pop      = htrans_q[1] && hwrite_q && HREADY;
  assign HWDATA      = wr_first_q ? wr_data : hwdata_q;

  assign cmd_ready   = (state_q == S_IDLE);
  assign HSEL        = (state_q inside {S_ADDR0, S_SEQ, S_LAST, S_ERR});
  assign HTRANS      = htrans_q;
  assign HADDR       = haddr_q;
  assign HWRITE      = hwrite_q;
  assign HBURST      = hburst_q;
  assign HSIZE       = 3'b010;
  assign HPROT       = HPROT_VAL;
  assign HMASTERLOCK = 1'b0;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign done        = done_q;
  assign done_err    = done_err_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_burst_master
//   Directed bench for ahb_burst_master: a behavioural AHB slave with word
//   memory, programmable wait states and one programmable ERROR address; a
//   write-word source answering wr_pop; bus monitors; and a linear sequence
//   of directed commands with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_ahb_burst_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_len;
  logic        wr_pop;
  logic [31:0] wr_data = '0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done, done_err;
  logic        HSEL, HWRITE, HMASTERLOCK;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HREADY, HRESP;

  always #5 HCLK = ~HCLK;

  ahb_burst_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_pop(wr_pop), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .done_err(done_err),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTERLOCK(HMASTERLOCK),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  // ---------------- behavioural slave ----------------
  logic [31:0] mem [0:1023];
  logic        dp_act, dp_wr, err_pend;
  logic [9:0]  dp_idx;
  int          wait_left;
  int          ws = 0;              // wait states per beat
  logic [11:0] err_addr = 12'hFFF;  // HADDR[11:0] answered with ERROR

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_act <= 1'b0; dp_wr <= 1'b0; dp_idx <= '0; err_pend <= 1'b0;
      HREADY <= 1'b1; HRESP <= 1'b0; wait_left <= 0;
    end else if (HREADY) begin
      if (dp_act && dp_wr && !HRESP) mem[dp_idx] <= HWDATA;
      if (HSEL && HTRANS[1]) begin
        dp_act <= 1'b1; dp_idx <= HADDR[11:2]; dp_wr <= HWRITE;
        if (HADDR[11:0] == err_addr) begin
          HREADY <= 1'b0; HRESP <= 1'b1; err_pend <= 1'b1;
        end else begin
          HRESP <= 1'b0; wait_left <= ws; HREADY <= (ws == 0);
        end
      end else begin
        dp_act <= 1'b0; HRESP <= 1'b0;
      end
    end else if (err_pend) begin
      HREADY <= 1'b1; err_pend <= 1'b0;
    end else begin
      wait_left <= wait_left - 1; HREADY <= (wait_left == 1);
    end
  end

  assign HRDATA = (dp_act && !dp_wr) ? mem[dp_idx] : '0;

  // ---------------- write-word source ----------------
  int          pop_seq  = 0;
  int          pop_base = 0;
  logic [31:0] wr_base  = '0;

  always @(posedge HCLK) begin
    if (wr_pop) begin
      wr_data <= wr_base + 32'(pop_seq - pop_base);
      pop_seq <= pop_seq + 1;
    end
  end

  // ---------------- monitors ----------------
  int          act_cnt = 0, ns_cnt = 0, sq_cnt = 0, done_cnt = 0;
  int          idle_run = 0, gap_last = 0, hold_viol = 0;
  logic [2:0]  last_hburst = '0;
  logic        last_err = 1'b0, ready_at_done = 1'b0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [1:0]  prev_trans = '0;
  logic [31:0] addr_log[$];
  logic [31:0] rd_log[$];

  always @(negedge HCLK) begin
    if (HRESET) begin
      prev_pend <= 1'b0;
    end else begin
      if (HTRANS != 2'b00) act_cnt <= act_cnt + 1;
      if (HTRANS == 2'b10) begin
        ns_cnt <= ns_cnt + 1; last_hburst <= HBURST; gap_last <= idle_run;
      end
      if (HTRANS == 2'b11) sq_cnt <= sq_cnt + 1;
      idle_run <= (HTRANS == 2'b00) ? idle_run + 1 : 0;
      if (HTRANS[1] && HREADY) addr_log.push_back(HADDR);
      if (rd_valid) rd_log.push_back(rd_data);
      if (done) begin
        done_cnt <= done_cnt + 1; last_err <= done_err; ready_at_done <= cmd_ready;
      end
      if (prev_pend && (HADDR != prev_addr || HTRANS != prev_trans))
        hold_viol <= hold_viol + 1;
      prev_pend  <= HTRANS[1] && !HREADY && !HRESP;
      prev_addr  <= HADDR;
      prev_trans <= HTRANS;
    end
  end

  // ---------------- checking helpers ----------------
  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge HCLK);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] l);
    cmd_write = w; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    @(posedge HCLK);
    #1 cmd_valid = 1'b0;
  endtask

  // Latency in cycles from the accepting edge to the cycle showing done.
  task automatic wait_done(input string tag, output int lat);
    int d0;
    d0  = done_cnt;
    lat = 0;
    while (done_cnt == d0 && lat < 200) begin
      tick();
      lat++;
    end
    if (done_cnt == d0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  int d0, ns0, sq0, act0, rd0, al0, lat;
  bit found;

  task automatic snap();
    d0 = done_cnt; ns0 = ns_cnt; sq0 = sq_cnt; act0 = act_cnt;
    rd0 = rd_log.size(); al0 = addr_log.size(); pop_base = pop_seq;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    @(posedge HCLK); #1;
    check("rst_htrans",   32'(HTRANS),    0);
    check("rst_hsel",     32'(HSEL),      0);
    check("rst_haddr",    HADDR,          0);
    check("rst_hwrite",   32'(HWRITE),    0);
    check("rst_hburst",   32'(HBURST),    0);
    check("rst_hwdata",   HWDATA,         0);
    check("rst_cmd_ready",32'(cmd_ready), 1);
    check("rst_wr_pop",   32'(wr_pop),    0);
    check("rst_rd_valid", 32'(rd_valid),  0);
    check("rst_done",     32'(done),      0);
    check("rst_done_err", 32'(done_err),  0);
    check("rst_hsize",    32'(HSIZE),     2);
    check("rst_hprot",    32'(HPROT),     3);
    check("rst_hmlock",   32'(HMASTERLOCK), 0);
    @(negedge HCLK); HRESET = 1'b0;
    tick();

    // 1: write INCR4 @0xC000_0100, no wait states
    wr_base = 32'hA000_0000; snap();
    issue(1'b1, 32'hC000_0100, 2'd1);
    wait_done("t1", lat);
    check("t1_latency", 32'(lat), 6);
    check("t1_pops",    32'(pop_seq - pop_base), 4);
    check("t1_nonseq",  32'(ns_cnt - ns0), 1);
    check("t1_seq",     32'(sq_cnt - sq0), 3);
    check("t1_hburst",  32'(last_hburst), 3);
    check("t1_done_cnt",32'(done_cnt - d0), 1);
    check("t1_done_err",32'(last_err), 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_addr%0d", k), addr_log[al0 + k], 32'hC000_0100 + 32'(4 * k));
      check($sformatf("t1_mem%0d", k),  mem[64 + k],       32'hA000_0000 + 32'(k));
    end

    // 2a: write INCR8 @0xC000_0200, no wait states
    wr_base = 32'hB000_0000; snap();
    issue(1'b1, 32'hC000_0200, 2'd2);
    wait_done("t2w", lat);
    check("t2w_latency", 32'(lat), 10);
    check("t2w_pops",    32'(pop_seq - pop_base), 8);
    check("t2w_done_err",32'(last_err), 0);

    // 2b: read it back with 2 wait states per beat
    ws = 2; snap();
    issue(1'b0, 32'hC000_0200, 2'd2);
    wait_done("t2r", lat);
    ws = 0;
    check("t2r_latency", 32'(lat), 26);
    check("t2r_hburst",  32'(last_hburst), 5);
    check("t2r_rd_cnt",  32'(rd_log.size() - rd0), 8);
    check("t2r_addr_cnt",32'(addr_log.size() - al0), 8);
    check("t2r_hold",    32'(hold_viol), 0);
    check("t2r_done_err",32'(last_err), 0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t2r_addr%0d", k), addr_log[al0 + k], 32'hC000_0200 + 32'(4 * k));
      check($sformatf("t2r_data%0d", k), rd_log[rd0 + k],   32'hB000_0000 + 32'(k));
    end

    // 3: SINGLE write then an immediate SINGLE read of the same word
    wr_base = 32'hC0DE_0000; snap();
    issue(1'b1, 32'hC000_0010, 2'd0);
    wait_done("t3w", lat);
    check("t3w_latency", 32'(lat), 3);
    check("t3w_hburst",  32'(last_hburst), 0);
    check("t3w_nonseq",  32'(ns_cnt - ns0), 1);
    check("t3w_seq",     32'(sq_cnt - sq0), 0);
    check("t3w_pops",    32'(pop_seq - pop_base), 1);
    check("t3w_ready",   32'(cmd_ready), 1);
    snap();
    issue(1'b0, 32'hC000_0010, 2'd0);
    wait_done("t3r", lat);
    check("t3r_latency", 32'(lat), 3);
    check("t3r_idle_gap",32'(gap_last), 2);
    check("t3r_rd_cnt",  32'(rd_log.size() - rd0), 1);
    check("t3r_data",    rd_log[rd0], 32'hC0DE_0000);
    check("t3r_done_err",32'(last_err), 0);

    // 4a: INCR16 crossing a 1 KB page -> rejected
    snap();
    issue(1'b1, 32'hC000_03C8, 2'd3);
    wait_done("t4a", lat);
    check("t4a_latency", 32'(lat), 1);
    check("t4a_done_err",32'(last_err), 1);
    check("t4a_ready_lo",32'(ready_at_done), 0);
    tick();
    check("t4a_ready_hi",32'(cmd_ready), 1);
    check("t4a_no_bus",  32'(act_cnt - act0), 0);

    // 4b: unaligned start -> rejected
    snap();
    issue(1'b0, 32'hC000_0102, 2'd1);
    wait_done("t4b", lat);
    check("t4b_latency", 32'(lat), 1);
    check("t4b_done_err",32'(last_err), 1);
    tick();
    check("t4b_no_bus",  32'(act_cnt - act0), 0);

    // 4c: INCR16 ending exactly on the page boundary is legal
    wr_base = 32'hD000_0000; snap();
    issue(1'b1, 32'hC000_03C0, 2'd3);
    wait_done("t4c", lat);
    check("t4c_latency", 32'(lat), 18);
    check("t4c_done_err",32'(last_err), 0);
    check("t4c_seq",     32'(sq_cnt - sq0), 15);
    check("t4c_hburst",  32'(last_hburst), 7);
    check("t4c_mem_last",mem[255], 32'hD000_000F);

    // 5: read INCR4 with ERROR on the second beat
    err_addr = 12'h804; snap();
    issue(1'b0, 32'hC000_0800, 2'd1);
    wait_done("t5", lat);
    err_addr = 12'hFFF;
    check("t5_latency",  32'(lat), 5);
    check("t5_done_err", 32'(last_err), 1);
    check("t5_rd_cnt",   32'(rd_log.size() - rd0), 1);
    check("t5_active",   32'(act_cnt - act0), 3);
    check("t5_addr_cnt", 32'(addr_log.size() - al0), 2);

    // 6: reset during the third beat of an INCR8 write
    wr_base = 32'hE000_0000; snap();
    issue(1'b1, 32'hC000_0300, 2'd2);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (HTRANS == 2'b11 && HADDR == 32'hC000_0308) found = 1'b1;
    end
    check("t6_reached_beat3", 32'(found), 1);
    HRESET = 1'b1;
    #1;
    check("t6_htrans", 32'(HTRANS), 0);
    check("t6_hsel",   32'(HSEL),   0);
    check("t6_haddr",  HADDR,       0);
    check("t6_hwrite", 32'(HWRITE), 0);
    check("t6_hburst", 32'(HBURST), 0);
    check("t6_hwdata", HWDATA,      0);
    check("t6_wr_pop", 32'(wr_pop), 0);
    d0 = done_cnt;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    repeat (4) tick();
    check("t6_no_done",  32'(done_cnt - d0), 0);
    check("t6_ready",    32'(cmd_ready), 1);
    check("t6_idle",     32'(HTRANS), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_burst_master.md
Name: ahb_burst_master

Overview:
- AHB-Lite bus-master engine that feeds the AHB slave port of the AHB-to-APB bridge.
- Takes single-burst commands from a local controller: start address, direction, length.
- Drives pipelined NONSEQ/SEQ word transfers with SINGLE/INCR4/INCR8/INCR16 encoding.
- Returns read data and a per-command completion/error status.

Parameters:
- ADDR_WIDTH, 32, HADDR and cmd_addr width.
- DATA_WIDTH, 32, HWDATA/HRDATA, wr_data and rd_data width.
- HPROT_VAL, 4'b0011, constant HPROT value (non-cacheable, privileged data).

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle and able to accept a command.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  ADDR_WIDTH  burst start byte address.
- cmd_len  in  2  burst length: 0=SINGLE(1), 1=INCR4, 2=INCR8, 3=INCR16.
- wr_pop  out  1  pulse; consumer pulls next write word.
- wr_data  in  DATA_WIDTH  write word; valid the cycle after wr_pop.
- rd_valid  out  1  one-cycle pulse per completed read beat.
- rd_data  out  DATA_WIDTH  read word, qualified by rd_valid.
- done  out  1  one-cycle pulse when a command finishes or is rejected.
- done_err  out  1  qualifies done: 1 on HRESP error or rejected command.
- HSEL  out  1  slave select; high while the engine is not IDLE.
- HADDR  out  ADDR_WIDTH  transfer address.
- HTRANS  out  2  IDLE=00, NONSEQ=10, SEQ=11; BUSY is never issued.
- HWRITE  out  1  transfer direction.
- HSIZE  out  3  fixed 3'b010 (word).
- HBURST  out  3  000 SINGLE, 011 INCR4, 101 INCR8, 111 INCR16.
- HPROT  out  4  = HPROT_VAL.
- HMASTERLOCK  out  1  tied 0.
- HWDATA  out  DATA_WIDTH  write data, data phase.
- HRDATA  in  DATA_WIDTH  read data from the bridge.
- HREADY  in  1  bridge HREADYOUT; low extends the current data phase.
- HRESP  in  1  0=OKAY, 1=ERROR (two-cycle response).

Behaviour:
- Reset (async, HRESET=1): registered outputs clear immediately:
  - HTRANS=IDLE, HSEL=0, HADDR=0, HWRITE=0, HBURST=0, HWDATA=0.
  - cmd_ready=1; wr_pop, rd_valid, done, done_err = 0.
  - State=IDLE; the beat counter clears.
  - Reset mid-burst abandons the burst with no done pulse.
- Command acceptance: cmd_valid & cmd_ready on a rising edge captures the command; cmd_ready drops the next cycle.
- Rejection, with no bus activity: cmd_addr[1:0]!=0, or start to end address crosses a 1 KB boundary (cmd_addr[9:0] + 4*len > 1024).
  - done=1, done_err=1 the following cycle.
  - cmd_ready returns to 1 one cycle later.
- States:
  - IDLE -> ADDR0 on an accepted legal command.
  - ADDR0 drives NONSEQ with HADDR=cmd_addr. With HREADY=1: SEQ when len>1, else LAST.
  - SEQ issues beat k at cmd_addr+4k, k=1..len-1. Each address/control update happens only on an edge with HREADY=1; outputs hold while HREADY=0.
  - LAST: address phase drives IDLE while the final data phase completes. With HREADY=1: IDLE, done=1, done_err=0.
  - ERR: covered under the error bullet below.
- Pipelining: the data phase of beat k overlaps the address phase of beat k+1.
  - Write: wr_pop pulses on the edge a write address phase is accepted (HTRANS non-IDLE and HREADY=1).
  - Write: HWDATA is registered from wr_data one cycle later and held until that data phase ends with HREADY=1.
  - Read: HRDATA is sampled on every edge that ends a read data phase with HREADY=1.
  - Read: rd_valid=1 and rd_data=HRDATA follow in the next cycle.
- Error: HRESP=1 with HREADY=0 (first error cycle) means HTRANS goes to IDLE on the next edge. Remaining beats are cancelled; no further wr_pop or rd_valid.
  - On the second error cycle (HRESP=1, HREADY=1): done=1, done_err=1, return to IDLE.
- Beat counter: 5 bits, counts address phases accepted; the burst ends when the count equals len. The address increment is fixed at 4; no wrapping.
- Back-to-back: a new command is accepted only in IDLE, so a minimum of one IDLE address cycle separates bursts.

Test Plan:
- Write INCR4 @0xC000_0100, HREADY always 1 -> NONSEQ then 3 SEQ at 0x104/0x108/0x10C, HBURST=011. 4 wr_pop pulses; HWDATA matches pops; single done with done_err=0 after the 4th data phase.
- Read INCR8 @0xC000_0200 with the bridge inserting 2 wait states per beat -> addresses held during HREADY=0. 8 rd_valid pulses with rd_data equal to the previously written values; done, done_err=0.
- SINGLE write @0xC000_0010 followed by an immediate read command -> one NONSEQ with HBURST=000, at least one IDLE cycle, then NONSEQ read; the read returns the same word.
- INCR16 @0xC000_03C8 (crosses 1 KB) and unaligned 0xC000_0102 -> no HTRANS activity; done=1, done_err=1 each.
- Read INCR4 to an unmapped address, slave returns ERROR on beat 2 -> HTRANS=IDLE after the first error cycle; only 1 rd_valid; done_err=1.
- Assert HRESET during beat 3 of an INCR8 write -> all bus outputs IDLE/0 asynchronously; no done pulse; cmd_ready=1 after release.
